// File: rtl/l1a_tag_fifo_pkg.sv
// Shared definitions for the L1A tag FIFO: default geometry, depth/count
// width helpers and the bit layout of the packed control-state word.
package l1a_tag_fifo_pkg;

   localparam int unsigned L1A_WIDTH_DEF  = 7;
   localparam int unsigned L1A_ADDR_W_DEF = 8;
   localparam int unsigned L1A_AFULL_DEF  = 192;

   // Low bits of the packed state word; pointers and count sit above them
   localparam int unsigned ST_FLAGS_W = 6;
   localparam int unsigned B_DV       = 0;
   localparam int unsigned B_UNF      = 1;
   localparam int unsigned B_OVF      = 2;
   localparam int unsigned B_AFULL    = 3;
   localparam int unsigned B_FULL     = 4;
   localparam int unsigned B_EMPTY    = 5;

   // DEPTH = 1 << ADDR_W; every entry is usable
   function automatic int unsigned fifo_depth(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // Occupancy needs one extra bit to represent a completely full FIFO
   function automatic int unsigned cnt_width(input int unsigned aw);
      return aw + 32'd1;
   endfunction

endpackage

// File: rtl/l1a_tag_fifo_ram.sv
// Tag storage: one write port and one registered read port. The read
// register reloads from the supplied hold value when no read happens, so
// under triplication a corrupted copy re-converges on the next edge.
module l1a_tag_fifo_ram
   import l1a_tag_fifo_pkg::*;
#(
   parameter int unsigned WIDTH  = L1A_WIDTH_DEF,
   parameter int unsigned ADDR_W = L1A_ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic [WIDTH-1:0]  hold,
   output logic [WIDTH-1:0]  rdata
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_W);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_d;
   logic [WIDTH-1:0] rd_q;

   // Write port; contents are deliberately left uninitialised on reset
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Select new read data on a read, otherwise keep the (voted) output
   always_comb begin
      rd_d = hold;
      if (re) rd_d = mem[raddr];
   end

   // Registered read port, cleared by reset so DOUT starts at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_d;
   end

   assign rdata = rd_q;

endmodule

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter shared by all triplicated blocks.
module tmr_vote #(
   parameter int unsigned W = 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] y
);

   assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/l1a_tag_fifo.sv
// Parametrised L1A tag FIFO between trigger accept and readout sequencer.
// All control state (pointers, count, flags, sticky errors, valid strobe)
// lives in one packed word per copy. With TMR every copy reloads from a
// next state computed from voted values, and every output is voted.
module l1a_tag_fifo
   import l1a_tag_fifo_pkg::*;
#(
   parameter int unsigned WIDTH     = L1A_WIDTH_DEF,
   parameter int unsigned ADDR_W    = L1A_ADDR_W_DEF,
   parameter int unsigned AFULL_THR = L1A_AFULL_DEF,
   parameter bit          TMR       = 1'b0
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic                              PUSH,
   input  logic [WIDTH-1:0]                  DIN,
   input  logic                              POP,
   input  logic                              CLR_ERR,
   output logic [WIDTH-1:0]                  DOUT,
   output logic                              DOUT_VALID,
   output logic                              EMPTY,
   output logic                              FULL,
   output logic                              AFULL,
   output logic [cnt_width(ADDR_W)-1:0]      COUNT,
   output logic                              OVF,
   output logic                              UNF
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_W);
   localparam int unsigned CW    = cnt_width(ADDR_W);
   localparam int unsigned SW    = 2 * ADDR_W + CW + ST_FLAGS_W;
   localparam int unsigned NC    = TMR ? 3 : 1;

   localparam logic [SW-1:0] ST_RST  = SW'(32'd1 << B_EMPTY);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THR);

   // Elaboration-time parameter sanity
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("l1a_tag_fifo: WIDTH must be 1..32");
   end
   if (AFULL_THR < 1 || AFULL_THR > DEPTH) begin : g_bad_afull
      $error("l1a_tag_fifo: AFULL_THR must be 1..DEPTH");
   end

   // Voted (or single-copy) current state
   logic [SW-1:0]     st_v;
   logic [ADDR_W-1:0] wa_v, ra_v;
   logic [CW-1:0]     cnt_v;
   logic              empty_v, full_v, afull_v, ovf_v, unf_v, dv_v;
   logic [WIDTH-1:0]  dout_v;

   // Next state shared by every copy
   logic [SW-1:0]     st_d;
   logic [ADDR_W-1:0] wa_d, ra_d;
   logic [CW-1:0]     cnt_d;
   logic              empty_d, full_d, afull_d, ovf_d, unf_d, dv_d;
   logic              ce_wr, ce_rd;

   // Per-copy state and read data before voting
   logic [SW-1:0]     st_cp [NC];
   logic [WIDTH-1:0]  rd_cp [NC];

   assign {wa_v, ra_v, cnt_v, empty_v, full_v, afull_v, ovf_v, unf_v, dv_v} = st_v;

   // Accept/advance logic; flags are derived from the next occupancy
   always_comb begin
      ce_wr   = PUSH & ~full_v;
      ce_rd   = POP & ~empty_v;
      wa_d    = wa_v + ADDR_W'(ce_wr);
      ra_d    = ra_v + ADDR_W'(ce_rd);
      cnt_d   = cnt_v + CW'(ce_wr) - CW'(ce_rd);
      empty_d = (cnt_d == '0);
      full_d  = (cnt_d == DEPTH_C);
      afull_d = (cnt_d >= AFULL_C);
      // A fresh error in the same cycle as the clear keeps the flag set
      ovf_d   = (ovf_v & ~CLR_ERR) | (PUSH & full_v);
      unf_d   = (unf_v & ~CLR_ERR) | (POP & empty_v);
      dv_d    = ce_rd;
      st_d    = {wa_d, ra_d, cnt_d, empty_d, full_d, afull_d, ovf_d, unf_d, dv_d};
   end

   for (genvar i = 0; i < NC; i++) begin : g_cp
      logic [SW-1:0] st_q;

      // Control-state copy; reloads from the voted next state each edge
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) st_q <= ST_RST;
         else        st_q <= st_d;
      end

      assign st_cp[i] = st_q;

      // Addresses come from voted pointers so all storage copies track
      l1a_tag_fifo_ram #(
         .WIDTH  (WIDTH),
         .ADDR_W (ADDR_W)
      ) u_ram (
         .clk   (CLK),
         .rst_n (RST_N),
         .we    (ce_wr),
         .waddr (wa_v),
         .wdata (DIN),
         .re    (ce_rd),
         .raddr (ra_v),
         .hold  (dout_v),
         .rdata (rd_cp[i])
      );
   end

   if (TMR) begin : g_vote
      tmr_vote #(.W(SW)) u_vote_st (
         .a (st_cp[0]),
         .b (st_cp[1]),
         .c (st_cp[2]),
         .y (st_v)
      );
      tmr_vote #(.W(WIDTH)) u_vote_rd (
         .a (rd_cp[0]),
         .b (rd_cp[1]),
         .c (rd_cp[2]),
         .y (dout_v)
      );
   end else begin : g_single
      assign st_v   = st_cp[0];
      assign dout_v = rd_cp[0];
   end

   assign DOUT       = dout_v;
   assign DOUT_VALID = dv_v;
   assign EMPTY      = empty_v;
   assign FULL       = full_v;
   assign AFULL      = afull_v;
   assign COUNT      = cnt_v;
   assign OVF        = ovf_v;
   assign UNF        = unf_v;

endmodule

// File: tb/tb_l1a_tag_fifo.sv
// Directed bench for l1a_tag_fifo: a plain instance and a TMR instance
// share inputs; the TMR copy is also checked with upset copies forced.
module tb_l1a_tag_fifo;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       PUSH = 1'b0;
   logic [6:0] DIN = '0;
   logic       POP = 1'b0;
   logic       CLR_ERR = 1'b0;

   logic [6:0] DOUT, DOUT_T;
   logic       DOUT_VALID, DOUT_VALID_T;
   logic       EMPTY, EMPTY_T, FULL, FULL_T, AFULL, AFULL_T;
   logic [8:0] COUNT, COUNT_T;
   logic       OVF, OVF_T, UNF, UNF_T;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   l1a_tag_fifo #(.WIDTH(7), .ADDR_W(8), .AFULL_THR(192), .TMR(1'b0)) dut (
      .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .DIN(DIN), .POP(POP), .CLR_ERR(CLR_ERR),
      .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .EMPTY(EMPTY), .FULL(FULL), .AFULL(AFULL),
      .COUNT(COUNT), .OVF(OVF), .UNF(UNF)
   );

   l1a_tag_fifo #(.WIDTH(7), .ADDR_W(8), .AFULL_THR(192), .TMR(1'b1)) dut_t (
      .CLK(CLK), .RST_N(RST_N), .PUSH(PUSH), .DIN(DIN), .POP(POP), .CLR_ERR(CLR_ERR),
      .DOUT(DOUT_T), .DOUT_VALID(DOUT_VALID_T), .EMPTY(EMPTY_T), .FULL(FULL_T), .AFULL(AFULL_T),
      .COUNT(COUNT_T), .OVF(OVF_T), .UNF(UNF_T)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      step();
      step();
      checks++;
      if ({EMPTY, FULL, AFULL, OVF, UNF, DOUT_VALID} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 100000", {EMPTY, FULL, AFULL, OVF, UNF, DOUT_VALID});
      end
      checks++;
      if (COUNT !== 9'd0 || DOUT !== 7'd0) begin
         errors++;
         $display("FAIL reset_count_dout got %0d/%h exp 0/00", COUNT, DOUT);
      end
      checks++;
      if ({EMPTY_T, FULL_T, AFULL_T, OVF_T, UNF_T, DOUT_VALID_T} !== 6'b100000 || COUNT_T !== 9'd0) begin
         errors++;
         $display("FAIL reset_tmr got %b/%0d exp 100000/0",
                  {EMPTY_T, FULL_T, AFULL_T, OVF_T, UNF_T, DOUT_VALID_T}, COUNT_T);
      end
      RST_N = 1'b1;
      step();
      checks++;
      if (COUNT !== 9'd0 || EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL reset_release got %0d/%b exp 0/1", COUNT, EMPTY);
      end
   endtask

   // Push 0x01..0x05 then pop back-to-back; t selects which instance is checked
   task automatic test_basic(input bit t);
      for (int i = 1; i <= 5; i++) begin
         PUSH = 1'b1;
         DIN  = 7'(i);
         step();
      end
      PUSH = 1'b0;
      checks++;
      if ((t ? COUNT_T : COUNT) !== 9'd5 || (t ? EMPTY_T : EMPTY) !== 1'b0) begin
         errors++;
         $display("FAIL basic_count tmr=%0d got %0d exp 5", t, t ? COUNT_T : COUNT);
      end
      POP = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if ((t ? DOUT_VALID_T : DOUT_VALID) !== 1'b1 || (t ? DOUT_T : DOUT) !== 7'(i)) begin
            errors++;
            $display("FAIL basic_pop%0d tmr=%0d got v=%b d=%h exp v=1 d=%h",
                     i, t, t ? DOUT_VALID_T : DOUT_VALID, t ? DOUT_T : DOUT, 7'(i));
         end
      end
      POP = 1'b0;
      checks++;
      if ((t ? EMPTY_T : EMPTY) !== 1'b1 || (t ? COUNT_T : COUNT) !== 9'd0) begin
         errors++;
         $display("FAIL basic_empty tmr=%0d got e=%b c=%0d exp e=1 c=0",
                  t, t ? EMPTY_T : EMPTY, t ? COUNT_T : COUNT);
      end
      step();
      checks++;
      if ((t ? DOUT_VALID_T : DOUT_VALID) !== 1'b0 || (t ? DOUT_T : DOUT) !== 7'h05) begin
         errors++;
         $display("FAIL basic_idle tmr=%0d got v=%b d=%h exp v=0 d=05",
                  t, t ? DOUT_VALID_T : DOUT_VALID, t ? DOUT_T : DOUT);
      end
   endtask

   task automatic test_underflow();
      POP = 1'b1;
      step();
      checks++;
      if (UNF !== 1'b1 || DOUT_VALID !== 1'b0 || COUNT !== 9'd0) begin
         errors++;
         $display("FAIL unf_set got u=%b v=%b c=%0d exp u=1 v=0 c=0", UNF, DOUT_VALID, COUNT);
      end
      POP = 1'b0;
      CLR_ERR = 1'b1;
      step();
      checks++;
      if (UNF !== 1'b0) begin
         errors++;
         $display("FAIL unf_clear got %b exp 0", UNF);
      end
      POP = 1'b1;
      step();
      checks++;
      if (UNF !== 1'b1) begin
         errors++;
         $display("FAIL unf_clr_race got %b exp 1", UNF);
      end
      POP = 1'b0;
      step();
      CLR_ERR = 1'b0;
      checks++;
      if (UNF !== 1'b0 || EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL unf_final got u=%b e=%b exp u=0 e=1", UNF, EMPTY);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 256; i++) begin
         PUSH = 1'b1;
         DIN  = 7'(i);
         step();
         if (i + 1 == 191) begin
            checks++;
            if (AFULL !== 1'b0) begin
               errors++;
               $display("FAIL afull_191 got %b exp 0", AFULL);
            end
         end
         if (i + 1 == 192) begin
            checks++;
            if (AFULL !== 1'b1) begin
               errors++;
               $display("FAIL afull_192 got %b exp 1", AFULL);
            end
         end
         if (i + 1 == 255) begin
            checks++;
            if (FULL !== 1'b0) begin
               errors++;
               $display("FAIL full_255 got %b exp 0", FULL);
            end
         end
      end
      checks++;
      if (FULL !== 1'b1 || AFULL !== 1'b1 || COUNT !== 9'd256 || OVF !== 1'b0) begin
         errors++;
         $display("FAIL full_256 got f=%b a=%b c=%0d o=%b exp 1/1/256/0", FULL, AFULL, COUNT, OVF);
      end
      DIN = 7'h55;
      step();
      PUSH = 1'b0;
      checks++;
      if (OVF !== 1'b1 || COUNT !== 9'd256 || FULL !== 1'b1) begin
         errors++;
         $display("FAIL ovf_push got o=%b c=%0d f=%b exp 1/256/1", OVF, COUNT, FULL);
      end
      POP = 1'b1;
      for (int i = 0; i < 256; i++) begin
         step();
         checks++;
         if (DOUT !== 7'(i) || DOUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL full_pop%0d got v=%b d=%h exp v=1 d=%h", i, DOUT_VALID, DOUT, 7'(i));
         end
         if (i == 64) begin
            checks++;
            if (AFULL !== 1'b0 || COUNT !== 9'd191) begin
               errors++;
               $display("FAIL afull_drop got a=%b c=%0d exp 0/191", AFULL, COUNT);
            end
         end
      end
      POP = 1'b0;
      checks++;
      if (EMPTY !== 1'b1 || COUNT !== 9'd0 || OVF !== 1'b1) begin
         errors++;
         $display("FAIL full_drained got e=%b c=%0d o=%b exp 1/0/1", EMPTY, COUNT, OVF);
      end
      CLR_ERR = 1'b1;
      step();
      CLR_ERR = 1'b0;
      checks++;
      if (OVF !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got %b exp 0", OVF);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         PUSH = 1'b1;
         DIN  = 7'(8'h10 + i);
         step();
      end
      POP = 1'b1;
      for (int k = 0; k < 600; k++) begin
         DIN = 7'(8'h13 + k);
         step();
         checks++;
         if (DOUT !== 7'(8'h10 + k) || COUNT !== 9'd3 || DOUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL stream%0d got d=%h c=%0d v=%b exp d=%h c=3 v=1",
                     k, DOUT, COUNT, DOUT_VALID, 7'(8'h10 + k));
         end
      end
      POP = 1'b0;
      for (int i = 0; i < 253; i++) begin
         DIN = 7'(i);
         step();
      end
      checks++;
      if (FULL !== 1'b1 || COUNT !== 9'd256) begin
         errors++;
         $display("FAIL stream_fill got f=%b c=%0d exp 1/256", FULL, COUNT);
      end
      POP = 1'b1;
      step();
      PUSH = 1'b0;
      POP  = 1'b0;
      checks++;
      if (COUNT !== 9'd255 || FULL !== 1'b0 || OVF !== 1'b1 || DOUT_VALID !== 1'b1) begin
         errors++;
         $display("FAIL full_pushpop got c=%0d f=%b o=%b v=%b exp 255/0/1/1", COUNT, FULL, OVF, DOUT_VALID);
      end
      CLR_ERR = 1'b1;
      step();
      CLR_ERR = 1'b0;
   endtask

   task automatic test_async_reset();
      // Clear leftovers with a mid-cycle reset pulse
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         PUSH = 1'b1;
         DIN  = 7'(8'h30 + i);
         step();
      end
      POP = 1'b1;
      DIN = 7'h3A;
      step();
      checks++;
      if (COUNT !== 9'd10 || DOUT !== 7'h30 || DOUT_VALID !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre got c=%0d d=%h v=%b exp 10/30/1", COUNT, DOUT, DOUT_VALID);
      end
      #3;
      RST_N = 1'b0;
      #1;
      checks++;
      if (COUNT !== 9'd0 || DOUT !== 7'd0 || {EMPTY, FULL, AFULL, OVF, UNF, DOUT_VALID} !== 6'b100000) begin
         errors++;
         $display("FAIL arst_now got c=%0d d=%h f=%b exp 0/00/100000",
                  COUNT, DOUT, {EMPTY, FULL, AFULL, OVF, UNF, DOUT_VALID});
      end
      PUSH = 1'b0;
      POP  = 1'b0;
      #1;
      RST_N = 1'b1;
      step();
      checks++;
      if (COUNT !== 9'd0 || DOUT_VALID !== 1'b0 || EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL arst_release got c=%0d v=%b e=%b exp 0/0/1", COUNT, DOUT_VALID, EMPTY);
      end
      PUSH = 1'b1;
      DIN  = 7'h2A;
      step();
      PUSH = 1'b0;
      POP  = 1'b1;
      step();
      POP = 1'b0;
      checks++;
      if (DOUT !== 7'h2A || DOUT_VALID !== 1'b1 || EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL arst_first got d=%h v=%b e=%b exp 2a/1/1", DOUT, DOUT_VALID, EMPTY);
      end
      step();
   endtask

   task automatic test_tmr();
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
      force dut_t.g_cp[1].st_q = '1;
      force dut_t.g_cp[0].u_ram.rd_q = 7'h7F;
      step();
      checks++;
      if (COUNT_T !== 9'd0 || DOUT_T !== 7'd0 ||
          {EMPTY_T, FULL_T, AFULL_T, OVF_T, UNF_T, DOUT_VALID_T} !== 6'b100000) begin
         errors++;
         $display("FAIL tmr_upset_idle got c=%0d d=%h f=%b exp 0/00/100000",
                  COUNT_T, DOUT_T, {EMPTY_T, FULL_T, AFULL_T, OVF_T, UNF_T, DOUT_VALID_T});
      end
      test_basic(1'b1);
      release dut_t.g_cp[1].st_q;
      release dut_t.g_cp[0].u_ram.rd_q;
      step();
      checks++;
      if (COUNT_T !== 9'd0 || EMPTY_T !== 1'b1 || DOUT_T !== 7'h05) begin
         errors++;
         $display("FAIL tmr_released got c=%0d e=%b d=%h exp 0/1/05", COUNT_T, EMPTY_T, DOUT_T);
      end
      test_basic(1'b1);
   endtask

   initial begin
      test_reset();
      test_basic(1'b0);
      test_underflow();
      test_full();
      test_back_to_back();
      test_async_reset();
      test_tmr();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
